// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator call scheduler.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package elevator_pkg;

   localparam int DEF_NUM_FLOORS = 8;
   // Widest floor vector the helper functions accept; callers zero-extend.
   localparam int MAX_FLOORS = 32;

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      WAIT,
      DWELL
   } state_e;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (v[i]) n++;
      end
      return (n == 1);
   endfunction

   // Index of the highest set bit; meaningful only for one-hot input.
   function automatic int floor_index(input logic [MAX_FLOORS-1:0] v);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Button/car-facing signal bundle of the call scheduler.
// Latency: none (wires only).
// Backpressure: none; car acceptance is signalled by car_complete.
interface elevator_call_scheduler_if
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS
);
   logic [NUM_FLOORS-1:0] call;
   logic [NUM_FLOORS-1:0] car_floor;
   logic                  car_complete;
   logic                  door_alert;
   logic                  weight_alert;
   logic [NUM_FLOORS-1:0] request_floor;
   logic                  request_valid;
   logic                  sched_dir;
   logic [NUM_FLOORS-1:0] pending;
   logic                  door_open;
   logic                  pos_error;

   // Environment side: buttons and car controller.
   modport master (
      output call, car_floor, car_complete, door_alert, weight_alert,
      input  request_floor, request_valid, sched_dir, pending, door_open, pos_error
   );

   // Scheduler side.
   modport slave (
      input  call, car_floor, car_complete, door_alert, weight_alert,
      output request_floor, request_valid, sched_dir, pending, door_open, pos_error
   );
endinterface

// File: rtl/elevator_floor_pick.sv
// SCAN target search: nearest pending floor in the current direction, else reverse.
// Latency: purely combinational.
// Backpressure: none.
module elevator_floor_pick
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [NUM_FLOORS-1:0] car_floor,
   input  logic                  sched_dir,
   output logic [NUM_FLOORS-1:0] target,
   output logic                  found,
   output logic                  next_dir
);

   logic [NUM_FLOORS-1:0] up_tgt;
   logic [NUM_FLOORS-1:0] dn_tgt;
   logic                  up_found;
   logic                  dn_found;
   int                    car_idx;

   // Nearest pending floor strictly above and strictly below the car.
   always_comb begin
      up_tgt   = '0;
      dn_tgt   = '0;
      up_found = 1'b0;
      dn_found = 1'b0;
      car_idx  = floor_index(MAX_FLOORS'(car_floor));
      // Descending walk: the last hit is the lowest floor above the car.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && (i > car_idx)) begin
            up_tgt    = '0;
            up_tgt[i] = 1'b1;
            up_found  = 1'b1;
         end
      end
      // Ascending walk: the last hit is the highest floor below the car.
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (i < car_idx)) begin
            dn_tgt    = '0;
            dn_tgt[i] = 1'b1;
            dn_found  = 1'b1;
         end
      end
   end

   // Prefer the current direction; reverse only when that side is empty.
   always_comb begin
      found = up_found | dn_found;
      if (sched_dir) begin
         target   = up_found ? up_tgt : dn_tgt;
         next_dir = up_found ? 1'b1 : !dn_found;
      end else begin
         target   = dn_found ? dn_tgt : up_tgt;
         next_dir = dn_found ? 1'b0 : up_found;
      end
   end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Holds floor calls and dispatches them one at a time to the car in SCAN order.
// Latency: call to request_valid is 2 cycles; arrival to next dispatch is DWELL_CYCLES+1.
// Backpressure: non-preemptive; one target outstanding until car_complete at that floor.
module elevator_call_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
   parameter int DWELL_CYCLES = 4
) (
   input logic                      clk,
   input logic                      reset,
   elevator_call_scheduler_if.slave bus
);

   localparam int               CW         = $clog2(DWELL_CYCLES + 1);
   localparam logic [CW-1:0]    DWELL_LOAD = CW'(DWELL_CYCLES);

   state_e                state_q, state_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic [NUM_FLOORS-1:0] req_q, req_d;
   logic                  dir_q, dir_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_FLOORS-1:0] clear;
   logic                  pos_error;
   logic                  car_ok;
   logic                  alert;
   logic [NUM_FLOORS-1:0] pick_tgt;
   logic                  pick_found;
   logic                  pick_dir;

   assign car_ok = is_onehot(MAX_FLOORS'(bus.car_floor));
   assign alert  = bus.door_alert | bus.weight_alert;

   elevator_floor_pick #(
      .NUM_FLOORS (NUM_FLOORS)
   ) u_pick (
      .pending   (pending_q),
      .car_floor (bus.car_floor),
      .sched_dir (dir_q),
      .target    (pick_tgt),
      .found     (pick_found),
      .next_dir  (pick_dir)
   );

   // Next-state, service clear and dwell counter control.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      clear     = '0;
      pos_error = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending_q != '0) state_d = SELECT;
         end
         SELECT: begin
            if (!car_ok) begin
               // Unknown car position: hold off dispatch until it is sane.
               pos_error = 1'b1;
            end else if ((pending_q & bus.car_floor) != '0) begin
               // Call at the car's own floor: open the door without a trip.
               clear   = pending_q & bus.car_floor;
               cnt_d   = DWELL_LOAD;
               state_d = DWELL;
            end else if (pick_found) begin
               req_d   = pick_tgt;
               dir_d   = pick_dir;
               state_d = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            // Arrival reports for any other floor are stale and ignored.
            if (bus.car_complete && (bus.car_floor == req_q)) begin
               clear   = req_q;
               req_d   = '0;
               cnt_d   = DWELL_LOAD;
               state_d = DWELL;
            end
         end
         DWELL: begin
            if (alert) begin
               cnt_d = DWELL_LOAD;
            end else if (cnt_q <= CW'(1)) begin
               cnt_d   = '0;
               state_d = SELECT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A call for the floor being served this cycle is absorbed.
      pending_d = (pending_q | bus.call) & ~clear;
   end

   // State, pending calls, target, direction and dwell counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         req_q     <= '0;
         dir_q     <= 1'b1;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         req_q     <= req_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.request_floor = req_q;
   assign bus.request_valid = (state_q == WAIT);
   assign bus.sched_dir     = dir_q;
   assign bus.pending       = pending_q;
   assign bus.door_open     = (state_q == DWELL);
   assign bus.pos_error     = pos_error;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler.
// Latency: n/a (simulation only).
// Backpressure: the bench plays the car and answers every dispatch.
module tb_elevator_call_scheduler;

   localparam int NF = 8;
   localparam int DW = 4;

   logic clk = 1'b0;
   logic reset;

   elevator_call_scheduler_if #(.NUM_FLOORS(NF)) bus ();

   elevator_call_scheduler #(
      .NUM_FLOORS   (NF),
      .DWELL_CYCLES (DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] car;
      logic [7:0] call;
      logic       valid;
      logic [7:0] req;
      logic       dir;
      logic [7:0] pend;
      logic       door;
   } vec_t;

   vec_t vecs[9];

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] fl(input int f);
      logic [7:0] v;
      v    = '0;
      v[f] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      bus.call         = '0;
      bus.car_complete = 1'b0;
      bus.door_alert   = 1'b0;
      bus.weight_alert = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Counts consecutive door-open samples starting at the current one.
   task automatic measure_door(output int n);
      n = 0;
      while (bus.door_open && n < 100) begin
         n++;
         tick();
      end
   endtask

   // Car arrives at its target: complete pulse sampled on the next edge.
   task automatic arrive(input logic [7:0] f);
      bus.car_floor    = f;
      bus.car_complete = 1'b1;
      tick();
      bus.car_complete = 1'b0;
   endtask

   // Randomized batches checked against a transaction-level SCAN model.
   task automatic random_batches(input int nb);
      int         mdir;
      int         pos;
      int         nxt;
      int         idx;
      int         budget;
      int         n;
      int         guard;
      logic [7:0] calls;
      logic [7:0] set;
      logic [7:0] tgt;
      logic [7:0] one;
      int         exp_q[$];
      bit         exp_disp[$];
      mdir = 1;
      one  = 8'h01;
      for (int b = 0; b < nb; b++) begin
         pos   = $urandom_range(0, NF - 1);
         calls = 8'($urandom_range(1, 255));
         bus.car_floor = one << pos;
         tick();
         // Expected stop order from the SCAN rules applied to the call set.
         exp_q.delete();
         exp_disp.delete();
         set = calls;
         if (set[pos]) begin
            exp_q.push_back(pos);
            exp_disp.push_back(1'b0);
            set[pos] = 1'b0;
         end
         guard = 0;
         while (set != 8'h00 && guard < 32) begin
            guard++;
            nxt = -1;
            for (int d = 1; d < NF && nxt < 0; d++) begin
               int f;
               f = (mdir != 0) ? pos + d : pos - d;
               if (f >= 0 && f < NF) begin
                  if (set[f]) nxt = f;
               end
            end
            if (nxt < 0) begin
               mdir = (mdir != 0) ? 0 : 1;
            end else begin
               exp_q.push_back(nxt);
               exp_disp.push_back(1'b1);
               set[nxt] = 1'b0;
               pos = nxt;
            end
         end
         bus.call = calls;
         tick();
         bus.call = '0;
         idx    = 0;
         budget = 400;
         while (idx < exp_q.size() && budget > 0) begin
            if (bus.request_valid) begin
               tgt = bus.request_floor;
               check8("rnd_target", tgt, fl(exp_q[idx]));
               check1("rnd_stop_dispatched", 1'b1, exp_disp[idx]);
               repeat ($urandom_range(1, 4)) begin
                  bus.door_alert = 1'($urandom_range(0, 1));
                  tick();
               end
               bus.door_alert = 1'b0;
               check8("rnd_target_held", bus.request_floor, tgt);
               arrive(tgt);
               measure_door(n);
               check8("rnd_dwell", 8'(n), 8'(DW));
               idx++;
            end else if (bus.door_open) begin
               check1("rnd_stop_dispatched", 1'b0, exp_disp[idx]);
               check8("rnd_same_floor", bus.car_floor, fl(exp_q[idx]));
               measure_door(n);
               check8("rnd_dwell", 8'(n), 8'(DW));
               idx++;
            end else begin
               tick();
               budget--;
            end
         end
         check8("rnd_stops_served", 8'(idx), 8'(exp_q.size()));
         repeat (3) tick();
         check8("rnd_pending_empty", bus.pending, 8'h00);
         check1("rnd_no_request", bus.request_valid, 1'b0);
         check1("rnd_dir", bus.sched_dir, mdir != 0);
      end
   endtask

   initial begin
      int n;
      int bad;

      //                car    call   vld   req    dir   pend   door
      vecs[0] = '{8'h01, 8'h10, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0};
      vecs[1] = '{8'h08, 8'h81, 1'b1, 8'h80, 1'b1, 8'h81, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0};
      vecs[3] = '{8'h10, 8'h24, 1'b1, 8'h20, 1'b1, 8'h24, 1'b0};
      vecs[4] = '{8'h10, 8'h05, 1'b1, 8'h04, 1'b0, 8'h05, 1'b0};
      vecs[5] = '{8'h04, 8'h04, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[6] = '{8'h40, 8'h7F, 1'b0, 8'h00, 1'b1, 8'h3F, 1'b1};
      vecs[7] = '{8'h02, 8'hFC, 1'b1, 8'h04, 1'b1, 8'hFC, 1'b0};
      vecs[8] = '{8'h08, 8'h11, 1'b1, 8'h10, 1'b1, 8'h11, 1'b0};

      // Reset values.
      reset            = 1'b1;
      bus.call         = '0;
      bus.car_floor    = 8'h01;
      bus.car_complete = 1'b0;
      bus.door_alert   = 1'b0;
      bus.weight_alert = 1'b0;
      tick();
      tick();
      check8("rst_pending", bus.pending, 8'h00);
      check8("rst_request_floor", bus.request_floor, 8'h00);
      check1("rst_request_valid", bus.request_valid, 1'b0);
      check1("rst_door_open", bus.door_open, 1'b0);
      check1("rst_pos_error", bus.pos_error, 1'b0);
      check1("rst_sched_dir", bus.sched_dir, 1'b1);
      reset = 1'b0;
      tick();

      // Table: first decision two edges after a single-cycle call burst.
      for (int i = 0; i < 9; i++) begin
         do_reset();
         bus.car_floor = vecs[i].car;
         bus.call      = vecs[i].call;
         tick();
         bus.call = '0;
         tick();
         check1("vec_valid_early", bus.request_valid, 1'b0);
         tick();
         check1("vec_valid", bus.request_valid, vecs[i].valid);
         check8("vec_request_floor", bus.request_floor, vecs[i].req);
         check1("vec_dir", bus.sched_dir, vecs[i].dir);
         check8("vec_pending", bus.pending, vecs[i].pend);
         check1("vec_door", bus.door_open, vecs[i].door);
      end

      // Basic dispatch through arrival, dwell and back to idle.
      do_reset();
      bus.car_floor = 8'h01;
      bus.call      = 8'h10;
      tick();
      bus.call = '0;
      tick();
      tick();
      check8("basic_request", bus.request_floor, 8'h10);
      arrive(8'h10);
      check8("basic_pending_cleared", bus.pending, 8'h00);
      check1("basic_valid_dropped", bus.request_valid, 1'b0);
      check8("basic_request_zeroed", bus.request_floor, 8'h00);
      measure_door(n);
      check8("basic_dwell_len", 8'(n), 8'(DW));
      repeat (3) tick();
      check1("basic_idle_no_request", bus.request_valid, 1'b0);
      check1("basic_idle_door", bus.door_open, 1'b0);

      // Clear-wins collision at the arrival edge.
      do_reset();
      bus.car_floor = 8'h01;
      bus.call      = 8'h10;
      tick();
      bus.call = '0;
      tick();
      tick();
      bus.call = 8'h10;
      arrive(8'h10);
      bus.call = '0;
      check8("collision_pending", bus.pending, 8'h00);
      measure_door(n);
      repeat (3) tick();
      check1("collision_no_redispatch", bus.request_valid, 1'b0);

      // SCAN order with a stale arrival report in between.
      do_reset();
      bus.car_floor = 8'h08;
      bus.call      = 8'h81;
      tick();
      bus.call = '0;
      tick();
      tick();
      check8("scan_first", bus.request_floor, 8'h80);
      check1("scan_first_dir", bus.sched_dir, 1'b1);
      arrive(8'h08);
      check1("scan_mismatch_ignored", bus.request_valid, 1'b1);
      check8("scan_mismatch_pending", bus.pending, 8'h81);
      // Door alert in WAIT must not stretch the following dwell.
      bus.door_alert = 1'b1;
      tick();
      tick();
      bus.door_alert = 1'b0;
      arrive(8'h80);
      check8("scan_after_first", bus.pending, 8'h01);
      measure_door(n);
      check8("scan_dwell_len", 8'(n), 8'(DW));
      check1("scan_select_gap", bus.request_valid, 1'b0);
      tick();
      check1("scan_second_valid", bus.request_valid, 1'b1);
      check8("scan_second", bus.request_floor, 8'h01);
      check1("scan_flipped_dir", bus.sched_dir, 1'b0);

      // Alert extension with a call queued during the held-open door.
      do_reset();
      bus.car_floor = 8'h04;
      bus.call      = 8'h04;
      tick();
      bus.call = '0;
      tick();
      tick();
      check1("alert_same_floor_door", bus.door_open, 1'b1);
      n   = 1;
      bad = 0;
      bus.weight_alert = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.call = (i == 3) ? 8'h80 : 8'h00;
         tick();
         if (bus.door_open) n++;
         if (bus.request_valid) bad++;
      end
      bus.weight_alert = 1'b0;
      bus.call         = '0;
      while (bus.door_open && n < 100) begin
         tick();
         if (bus.door_open) n++;
         if (bus.request_valid) bad++;
      end
      check8("alert_door_len", 8'(n), 8'(10 + DW));
      check8("alert_no_dispatch", 8'(bad), 8'h00);
      tick();
      check1("alert_then_dispatch", bus.request_valid, 1'b1);
      check8("alert_then_target", bus.request_floor, 8'h80);

      // Asynchronous reset in WAIT, then a corrupt car position in SELECT.
      do_reset();
      bus.car_floor = 8'h80;
      bus.call      = 8'h22;
      tick();
      bus.call = '0;
      tick();
      tick();
      check1("rwait_valid", bus.request_valid, 1'b1);
      check8("rwait_target", bus.request_floor, 8'h20);
      check1("rwait_dir_down", bus.sched_dir, 1'b0);
      #2 reset = 1'b1;
      #1;
      check1("rwait_async_valid", bus.request_valid, 1'b0);
      check8("rwait_async_pending", bus.pending, 8'h00);
      check8("rwait_async_request", bus.request_floor, 8'h00);
      check1("rwait_async_door", bus.door_open, 1'b0);
      check1("rwait_async_dir", bus.sched_dir, 1'b1);
      tick();
      reset = 1'b0;
      bus.car_floor = 8'h06;
      bus.call      = 8'h01;
      tick();
      bus.call = '0;
      tick();
      check1("poserr_raised", bus.pos_error, 1'b1);
      tick();
      check1("poserr_held", bus.pos_error, 1'b1);
      check1("poserr_no_dispatch", bus.request_valid, 1'b0);
      bus.car_floor = 8'h02;
      #1;
      check1("poserr_cleared", bus.pos_error, 1'b0);
      tick();
      check1("poserr_recover_valid", bus.request_valid, 1'b1);
      check8("poserr_recover_target", bus.request_floor, 8'h01);
      check1("poserr_recover_dir", bus.sched_dir, 1'b0);

      // Randomized batches against the SCAN model.
      do_reset();
      random_batches(25);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Collects floor calls from hall/car buttons, holds them in a pending register, and dispatches them one at a time to the `elevator` car controller using a SCAN (keep-direction-then-reverse) policy. It sits between the button inputs and the `elevator` block. It drives the car's `request_floor` and consumes its `out_current_floor`, `complete`, `door_alert` and `weight_alert`.

## Interface
- `NUM_FLOORS`, 8: number of floors; width of every floor vector. Bit 0 is the lowest floor.
- `DWELL_CYCLES`, 4: door-open cycles after arrival before the next dispatch. Must be ≥1.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `call`  in  NUM_FLOORS  button presses; any number of bits may be high in a cycle.
- `car_floor`  in  NUM_FLOORS  one-hot car position, from `out_current_floor`.
- `car_complete`  in  1  car reports arrival at the requested floor.
- `door_alert`  in  1  door obstruction/over-time from the car.
- `weight_alert`  in  1  overload from the car.
- `request_floor`  out  NUM_FLOORS  one-hot target to the car; all-zero when no target.
- `request_valid`  out  1  `request_floor` is a live target.
- `sched_dir`  out  1  scan direction: 1 = up, 0 = down.
- `pending`  out  NUM_FLOORS  registered outstanding calls.
- `door_open`  out  1  high during DWELL.
- `pos_error`  out  1  high while `car_floor` is not one-hot in SELECT.

## Operation
- Reset values:
  - `pending`, `request_floor`, `request_valid`, `door_open` and `pos_error` are all 0.
  - `sched_dir` is 1.
  - State is IDLE and the dwell counter is 0.
- Pending register: `pending <= (pending | call) & ~clear`.
  - `clear` is the served floor's one-hot, asserted for one cycle on service.
  - A `call` bit equal to the floor being cleared in that cycle is absorbed; clear wins.
- **IDLE**: go to SELECT when `pending != 0`.
- **SELECT**:
  - If `car_floor` is not one-hot, stay in SELECT and assert `pos_error`.
  - If `pending & car_floor` is nonzero, clear that bit and go to DWELL without dispatching.
  - Otherwise search from the car position in direction `sched_dir` for the nearest pending floor (strictly above for up, strictly below for down).
  - If none is found, flip `sched_dir` and search the other side.
  - If a floor is found, register it into `request_floor` and go to WAIT.
  - If `pending` is 0, return to IDLE.
- **WAIT**:
  - `request_valid = 1` and `request_floor` is held stable.
  - Non-preemptive: new calls are only added to `pending`.
  - On `car_complete && car_floor == request_floor`: clear that bit, drop `request_valid`, zero `request_floor`, load the dwell counter with `DWELL_CYCLES`, and go to DWELL.
  - `car_complete` with a mismatched floor is ignored.
- **DWELL**:
  - `door_open = 1`; the counter decrements each cycle.
  - While `door_alert` or `weight_alert` is high, the counter reloads to `DWELL_CYCLES`, so the door stays open.
  - When the counter reaches 1 with no alert, go to SELECT.
- Alerts have no effect in IDLE, SELECT or WAIT.

## Timing
- A `call` sampled at edge k appears in `pending` after k. IDLE moves to SELECT at k+1. `request_valid` rises after edge k+2.
- From `car_complete` sampled at edge m:
  - `door_open` is high after m.
  - With no alerts, SELECT is entered after m+DWELL_CYCLES.
  - The next `request_valid` follows one cycle later.
- `reset` asserted in any state returns to reset values immediately (asynchronously) and discards all pending calls.
- Direction flips only in SELECT, never mid-trip.

## Structure
- Package `elevator_pkg` holds:
  - the state enum (IDLE, SELECT, WAIT, DWELL);
  - the default `NUM_FLOORS`;
  - functions `is_onehot` and `floor_index`.
- Sub-module `elevator_floor_pick` is purely combinational.
  - Inputs: `pending`, `car_floor`, `sched_dir`.
  - Outputs: the one-hot target, a found flag, and the next direction.
  - It performs the directional priority search, including the reversal.
- The top level holds the pending register, FSM and dwell counter.

## Test plan
- **Basic dispatch.** Stimulus: car at 8'h01, call 8'h10 for one cycle. Response: `request_floor` = 8'h10 and `request_valid` = 1 two cycles later; `car_complete` clears `pending`; `door_open` is high for 4 cycles, then the block returns to IDLE.
- **SCAN order.** Stimulus: car at 8'h08 with `sched_dir` up, calls 8'h81 together. Response: 8'h80 is served first, then direction flips and 8'h01 is served.
- **Same-floor call.** Stimulus: car at 8'h04, call 8'h04. Response: no `request_valid`; DWELL is entered directly; `pending` returns to 0.
- **Alert extension.** Stimulus: `weight_alert` held 10 cycles during DWELL. Response: `door_open` stays high for 10 + 4 cycles; no dispatch during the alert.
- **Clear-wins collision.** Stimulus: call 8'h10 in the same cycle the 8'h10 arrival is cleared. Response: `pending[4]` = 0 afterwards.
- **Reset mid-WAIT.** Stimulus: assert `reset` with `pending` = 8'h22. Response: `request_valid`, `pending`, `request_floor` and `door_open` are 0 immediately and `sched_dir` = 1; a non-one-hot `car_floor` (8'h06) in SELECT raises `pos_error`.
